wb_mem_slave: RTL

- Parametrised Wishbone classic-cycle memory slave; next generation of the team's 8-bit single-width memory slave.
- Adds configurable data width, depth and wait states, byte-lane selects, and a post-reset initialisation sweep.
- Adds cycle abort on cyc deassertion and out-of-range error signalling.
- Sits behind a Wishbone master or interconnect as a scratch/test memory for bus verification.

---
 rtl/wb_mem_slave_if.sv | 35 +++
 rtl/wb_mem_slave.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/wb_mem_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_mem_if (interface)
//  Description : Wishbone classic-cycle bus bundle for wb_mem_slave.
//                master modport drives the request (cyc, stb, we, sel,
//                addr, wdata) and receives the response (rdata, ack, err,
//                init_busy). The slave modport has the opposite directions.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_mem_if #(
   parameter int DW = 32,
   parameter int AW = 8
);
   logic            cyc;
   logic            stb;
   logic            we;
   logic [DW/8-1:0] sel;
   logic [AW-1:0]   addr;
   logic [DW-1:0]   wdata;
   logic [DW-1:0]   rdata;
   logic            ack;
   logic            err;
   logic            init_busy;

   modport master (
      output cyc, stb, we, sel, addr, wdata,
      input  rdata, ack, err, init_busy
   );

   modport slave (
      input  cyc, stb, we, sel, addr, wdata,
      output rdata, ack, err, init_busy
   );
endinterface
`default_nettype wire

// File: rtl/wb_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module      : wb_mem_slave
//  Description : Parametrised Wishbone classic-cycle memory slave with
//                byte-lane selects, configurable wait states and a
//                post-reset sweep that fills every word with INIT_VAL.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset; aborts any transfer
//                       and restarts the init sweep
//                bus  - wb_mem_if.slave (cyc, stb, we, sel, addr, wdata in;
//                       rdata, ack, err, init_busy out)
//  Options     : WB_MEM_ADDR_CHECK_EN - when defined, addr >= DEPTH ends
//                with err instead of ack; when undefined err is 0 and the
//                address wraps modulo DEPTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_mem_slave #(
   parameter int            DW          = 32,
   parameter int            AW          = 8,
   parameter int            DEPTH       = 256,
   parameter int            WAIT_STATES = 0,
   parameter logic [DW-1:0] INIT_VAL    = DW'(32'h11111111)
) (
   input  wire logic clk,
   input  wire logic rst,
   wb_mem_if.slave   bus
);
   localparam int          c_NB      = DW / 8;
   localparam logic [AW-1:0] c_LAST  = AW'(DEPTH - 1);
   localparam logic [3:0]  c_WS_LAST = 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {
      S_INIT = 2'd0,
      S_IDLE = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t            r_state;
   logic [AW-1:0]     r_ptr;
   logic [3:0]        r_wcnt;
   logic              r_we;
   logic [c_NB-1:0]   r_sel;
   logic [AW-1:0]     r_addr;
   logic [DW-1:0]     r_wdata;
   logic [DW-1:0]     r_rdata;
   logic              r_ack;
   logic              r_err;
   logic              r_busy;
   logic [DW-1:0]     r_mem [DEPTH];

   logic              w_req;
   logic              w_go_resp;
   logic              w_oob;
   logic              w_cur_we;
   logic [c_NB-1:0]   w_cur_sel;
   logic [AW-1:0]     w_cur_addr;
   logic [AW-1:0]     w_rd_idx;
   logic [AW-1:0]     w_wr_idx;
   logic [DW-1:0]     w_rd_mask;
   logic [DW-1:0]     w_wr_mask;

   function automatic logic [AW-1:0] f_wrap(input logic [AW-1:0] a);
      return AW'(32'(a) % 32'(DEPTH));
   endfunction

   assign w_req = bus.cyc & bus.stb;

   // With zero wait states the response is decided straight from the bus
   // inputs in IDLE; otherwise the values latched at acceptance are used.
   assign w_cur_we   = (r_state == S_IDLE) ? bus.we   : r_we;
   assign w_cur_sel  = (r_state == S_IDLE) ? bus.sel  : r_sel;
   assign w_cur_addr = (r_state == S_IDLE) ? bus.addr : r_addr;

   assign w_go_resp = ((r_state == S_IDLE) && w_req && (WAIT_STATES == 0)) ||
                      ((r_state == S_WAIT) && bus.cyc && (r_wcnt == 4'd0));

   assign w_rd_idx = f_wrap(w_cur_addr);
   assign w_wr_idx = f_wrap(r_addr);

`ifdef WB_MEM_ADDR_CHECK_EN
   assign w_oob = (32'(w_cur_addr) >= 32'(DEPTH));
`else
   assign w_oob = 1'b0;
`endif

   for (genvar i = 0; i < c_NB; i++) begin : g_lane
      assign w_rd_mask[8*i +: 8] = {8{w_cur_sel[i]}};
      assign w_wr_mask[8*i +: 8] = {8{r_sel[i]}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_INIT;
         r_ptr   <= '0;
         r_wcnt  <= '0;
         r_we    <= 1'b0;
         r_sel   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_busy  <= 1'b1;
      end else begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         // Response flags and read data are registered on entry to RESP so
         // they are valid for exactly the RESP cycle.
         if (w_go_resp) begin
            if (w_oob) begin
               r_err <= 1'b1;
            end else begin
               r_ack <= 1'b1;
               if (!w_cur_we) begin
                  r_rdata <= r_mem[w_rd_idx] & w_rd_mask;
               end
            end
         end
         case (r_state)
            S_INIT: begin
               r_ptr <= r_ptr + 1'b1;
               if (r_ptr == c_LAST) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            S_IDLE: begin
               if (w_req) begin
                  r_we    <= bus.we;
                  r_sel   <= bus.sel;
                  r_addr  <= bus.addr;
                  r_wdata <= bus.wdata;
                  if (WAIT_STATES == 0) begin
                     r_state <= S_RESP;
                  end else begin
                     r_state <= S_WAIT;
                     r_wcnt  <= c_WS_LAST;
                  end
               end
            end
            S_WAIT: begin
               if (!bus.cyc) begin
                  r_state <= S_IDLE;
               end else if (r_wcnt == 4'd0) begin
                  r_state <= S_RESP;
               end else begin
                  r_wcnt <= r_wcnt - 1'b1;
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_INIT;
            end
         endcase
      end
   end

   // Memory array: filled by the sweep, updated at the end of an acked
   // write's RESP cycle (r_ack is only set for in-range transfers).
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (r_state == S_INIT) begin
            r_mem[r_ptr] <= INIT_VAL;
         end else if ((r_state == S_RESP) && r_ack && r_we) begin
            r_mem[w_wr_idx] <= (r_mem[w_wr_idx] & ~w_wr_mask) |
                               (r_wdata & w_wr_mask);
         end
      end
   end

   assign bus.rdata     = r_rdata;
   assign bus.ack       = r_ack;
   assign bus.err       = r_err;
   assign bus.init_busy = r_busy;
endmodule
`default_nettype wire
